// File: rtl/adsr_voice_sched.sv
// Per-voice context store and sequencer around the combinational ADSR step function.
// Each tick sweeps all voices one per clock, writes back the ADSR result and streams a clamped level.
module adsr_voice_sched #(
    parameter int NUM_VOICES = 16,
    parameter int VOICE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               note_on,
    input  logic               note_off,
    input  logic [VOICE_W-1:0] voice_idx,
    input  logic [6:0]         velocity,
    output logic [6:0]         adsr_velocity,
    output logic [2:0]         adsr_state,
    output logic [17:0]        adsr_volume,
    output logic               adsr_pressed,
    output logic               adsr_released,
    input  logic [2:0]         adsr_next_state,
    input  logic [17:0]        adsr_next_volume,
    output logic               env_valid,
    output logic [VOICE_W-1:0] env_voice,
    output logic [16:0]        env_level,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } sched_state_t;

    sched_state_t       state_q, state_d;
    logic [VOICE_W-1:0] cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               ovr_d;
    logic               last_cyc;
    logic               sweep_en;
    logic               note_hit;

    logic [NUM_VOICES-1:0][2:0]  st_mem;
    logic [NUM_VOICES-1:0][17:0] vol_mem;
    logic [NUM_VOICES-1:0][6:0]  vel_mem;
    logic [NUM_VOICES-1:0]       pr_mem;
    logic [NUM_VOICES-1:0]       rl_mem;

    assign sweep_en = (state_q == S_SWEEP);
    assign busy     = sweep_en;
    assign last_cyc = (cnt_q == VOICE_W'(NUM_VOICES - 1));
    assign note_hit = ({1'b0, voice_idx} < (VOICE_W + 1)'(NUM_VOICES));

    // The counter rests at 0 when idle, so the ADSR port shows voice 0's context.
    assign adsr_velocity = vel_mem[cnt_q];
    assign adsr_state    = st_mem[cnt_q];
    assign adsr_volume   = vol_mem[cnt_q];
    assign adsr_pressed  = pr_mem[cnt_q];
    assign adsr_released = rl_mem[cnt_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SWEEP;
                    cnt_d   = '0;
                end
            end
            S_SWEEP: begin
                if (last_cyc) begin
                    // A pending tick, or a fresh one on the last cycle, chains the next sweep with no gap.
                    cnt_d  = '0;
                    pend_d = 1'b0;
                    ovr_d  = tick & pend_q;
                    if (!(tick || pend_q)) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (tick) begin
                        if (pend_q) begin
                            ovr_d = 1'b1;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            overrun <= ovr_d;
        end
    end

    // Note events are applied after the writeback clear so a coincident event always survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mem  <= '0;
            vol_mem <= '0;
            vel_mem <= '0;
            pr_mem  <= '0;
            rl_mem  <= '0;
        end else begin
            if (sweep_en) begin
                st_mem[cnt_q]  <= adsr_next_state;
                vol_mem[cnt_q] <= adsr_next_volume;
                pr_mem[cnt_q]  <= 1'b0;
                rl_mem[cnt_q]  <= 1'b0;
            end
            if (note_hit) begin
                if (note_on) begin
                    pr_mem[voice_idx]  <= 1'b1;
                    rl_mem[voice_idx]  <= 1'b0;
                    vel_mem[voice_idx] <= velocity;
                end else if (note_off) begin
                    rl_mem[voice_idx] <= 1'b1;
                    pr_mem[voice_idx] <= 1'b0;
                end
            end
        end
    end

    // env_valid has no back-pressure: the consumer must take every beat in the cycle it is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_valid <= 1'b0;
            env_voice <= '0;
            env_level <= '0;
        end else begin
            env_valid <= sweep_en;
            if (sweep_en) begin
                env_voice <= cnt_q;
                env_level <= adsr_next_volume[17] ? 17'd0 : adsr_next_volume[16:0];
            end
        end
    end

endmodule

// File: tb/tb_adsr_voice_sched.sv
// Bench for adsr_voice_sched: a simple ADSR step function closes the loop, and a per-voice
// sweep-level model predicts every presented context and every streamed envelope beat.
module tb_adsr_voice_sched;

    localparam int NV = 16;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          note_on;
    logic          note_off;
    logic [VW-1:0] voice_idx;
    logic [6:0]    velocity;
    logic [6:0]    adsr_velocity;
    logic [2:0]    adsr_state;
    logic [17:0]   adsr_volume;
    logic          adsr_pressed;
    logic          adsr_released;
    logic [2:0]    adsr_next_state;
    logic [17:0]   adsr_next_volume;
    logic          env_valid;
    logic [VW-1:0] env_voice;
    logic [16:0]   env_level;
    logic          busy;
    logic          overrun;

    adsr_voice_sched #(.NUM_VOICES(NV), .VOICE_W(VW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tick             (tick),
        .note_on          (note_on),
        .note_off         (note_off),
        .voice_idx        (voice_idx),
        .velocity         (velocity),
        .adsr_velocity    (adsr_velocity),
        .adsr_state       (adsr_state),
        .adsr_volume      (adsr_volume),
        .adsr_pressed     (adsr_pressed),
        .adsr_released    (adsr_released),
        .adsr_next_state  (adsr_next_state),
        .adsr_next_volume (adsr_next_volume),
        .env_valid        (env_valid),
        .env_voice        (env_voice),
        .env_level        (env_level),
        .busy             (busy),
        .overrun          (overrun)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- ADSR step function (attack 100, decay 50, release 127) ----------------
    function automatic logic [20:0] adsr_fn(input logic [2:0] st, input logic [17:0] vol,
                                           input logic [6:0] vel, input logic pr, input logic rl);
        logic [2:0]  ns;
        logic [17:0] nv;
        logic [17:0] sus;
        sus = {8'd0, vel, 3'd0};
        ns  = st;
        nv  = vol;
        if (pr) begin
            ns = 3'd1;
        end else if (rl) begin
            ns = 3'd4;
        end else begin
            case (st)
                3'd1: begin
                    nv = vol + 18'd100;
                    ns = (nv >= 18'd1000) ? 3'd2 : 3'd1;
                end
                3'd2: begin
                    nv = vol - 18'd50;
                    if (nv <= sus) begin
                        ns = 3'd3;
                        nv = sus;
                    end
                end
                3'd3: ns = 3'd3;
                3'd4: begin
                    if (vol[17]) begin
                        ns = 3'd0;
                        nv = 18'd0;
                    end else begin
                        nv = vol - 18'd127;
                    end
                end
                default: begin
                    ns = 3'd0;
                    nv = 18'd0;
                end
            endcase
        end
        return {ns, nv};
    endfunction

    always_comb begin
        {adsr_next_state, adsr_next_volume} =
            adsr_fn(adsr_state, adsr_volume, adsr_velocity, adsr_pressed, adsr_released);
    end

    // ---------------- scoreboard ----------------
    logic [29:0] exp_ctx_q[$];
    logic [20:0] exp_env_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          busy_cnt = 0;
    int          ovr_cnt  = 0;
    logic [16:0] last_lvl [NV];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                busy_cnt++;
                check("ctx_expected", 64'(exp_ctx_q.size() != 0), 64'd1);
                if (exp_ctx_q.size() != 0) begin
                    check("ctx", 64'({adsr_velocity, adsr_state, adsr_volume, adsr_pressed, adsr_released}),
                          64'(exp_ctx_q.pop_front()));
                end
            end
            if (env_valid) begin
                check("env_expected", 64'(exp_env_q.size() != 0), 64'd1);
                if (exp_env_q.size() != 0) begin
                    check("env", 64'({env_voice, env_level}), 64'(exp_env_q.pop_front()));
                end
                last_lvl[env_voice] = env_level;
            end
            if (overrun) ovr_cnt++;
        end
    end

    // ---------------- reference model: voice contexts updated a whole sweep at a time ----------------
    logic [2:0]  m_st  [NV];
    logic [17:0] m_vol [NV];
    logic [6:0]  m_vel [NV];
    logic        m_pr  [NV];
    logic        m_rl  [NV];

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_st[v] = 3'd0; m_vol[v] = 18'd0; m_vel[v] = 7'd0; m_pr[v] = 1'b0; m_rl[v] = 1'b0;
        end
        exp_ctx_q.delete();
        exp_env_q.delete();
    endtask

    task automatic model_event(input int v, input logic on, input logic off, input logic [6:0] vel);
        if (on) begin
            m_pr[v] = 1'b1; m_rl[v] = 1'b0; m_vel[v] = vel;
        end else if (off) begin
            m_rl[v] = 1'b1; m_pr[v] = 1'b0;
        end
    endtask

    // An event in sweep cycle ev_k reaches voice ev_v before its own step only if ev_k < ev_v.
    task automatic model_sweep(input logic ev_en, input int ev_v, input int ev_k,
                               input logic on, input logic off, input logic [6:0] vel);
        logic [20:0]   r;
        logic [16:0]   lvl;
        logic [VW-1:0] vi;
        for (int v = 0; v < NV; v++) begin
            if (ev_en && ev_v == v && ev_k < v) model_event(v, on, off, vel);
            exp_ctx_q.push_back({m_vel[v], m_st[v], m_vol[v], m_pr[v], m_rl[v]});
            r   = adsr_fn(m_st[v], m_vol[v], m_vel[v], m_pr[v], m_rl[v]);
            lvl = r[17] ? 17'd0 : r[16:0];
            vi  = VW'(v);
            exp_env_q.push_back({vi, lvl});
            m_st[v] = r[20:18]; m_vol[v] = r[17:0]; m_pr[v] = 1'b0; m_rl[v] = 1'b0;
            if (ev_en && ev_v == v && ev_k >= v) model_event(v, on, off, vel);
        end
    endtask

    // ---------------- driver tasks (entered and left 1 time unit after a rising edge) ----------------
    task automatic note(input int v, input logic on, input logic off, input logic [6:0] vel);
        voice_idx = VW'(v); note_on = on; note_off = off; velocity = vel;
        model_event(v, on, off, vel);
        @(posedge clk); #1;
        note_on = 1'b0; note_off = 1'b0;
    endtask

    task automatic sweep(input logic ev_en, input int ev_v, input int ev_k,
                         input logic on, input logic off, input logic [6:0] vel);
        model_sweep(ev_en, ev_v, ev_k, on, off, vel);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        for (int j = 0; j < NV; j++) begin
            if (ev_en && j == ev_k) begin
                voice_idx = VW'(ev_v); note_on = on; note_off = off; velocity = vel;
            end
            @(posedge clk); #1;
            note_on = 1'b0; note_off = 1'b0;
        end
        check("busy_after_sweep", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_env_valid"}, 64'(env_valid), 64'd0);
        check({tag, "_env_voice"}, 64'(env_voice), 64'd0);
        check({tag, "_env_level"}, 64'(env_level), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
        check({tag, "_adsr_ctx"},
              64'({adsr_velocity, adsr_state, adsr_volume, adsr_pressed, adsr_released}), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    int lv3 [3] = '{0, 100, 200};
    int b0;
    int o0;

    initial begin
        rst_n = 1'b0; tick = 1'b0; note_on = 1'b0; note_off = 1'b0;
        voice_idx = '0; velocity = '0;
        for (int v = 0; v < NV; v++) last_lvl[v] = 17'h1ffff;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // reset asserted in sweep cycle k=5 aborts everything
        note(5, 1'b1, 1'b0, 7'd20);
        model_sweep(1'b0, 0, 0, 1'b0, 1'b0, 7'd0);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_sweep_reset");
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        b0 = busy_cnt;
        sweep(1'b0, 0, 0, 1'b0, 1'b0, 7'd0);
        check("busy_len_after_reset", 64'(busy_cnt - b0), 64'd16);

        // note-on, attack ramp on voice 3
        note(3, 1'b1, 1'b0, 7'd64);
        for (int s = 0; s < 3; s++) begin
            sweep(1'b0, 0, 0, 1'b0, 1'b0, 7'd0);
            check("v3_attack_level", 64'(last_lvl[3]), 64'(lv3[s]));
        end

        // voice 2 to sustain at 1000, then release through underflow to BLANK
        note(2, 1'b1, 1'b0, 7'd125);
        for (int s = 0; s < 12; s++) sweep(1'b0, 0, 0, 1'b0, 1'b0, 7'd0);
        check("v2_sustain_level", 64'(last_lvl[2]), 64'd1000);
        note(2, 1'b0, 1'b1, 7'd0);
        for (int s = 1; s <= 10; s++) begin
            sweep(1'b0, 0, 0, 1'b0, 1'b0, 7'd0);
            if (s == 8) check("v2_release_level", 64'(last_lvl[2]), 64'd111);
            if (s == 9) check("v2_underflow_clamped", 64'(last_lvl[2]), 64'd0);
        end

        // note_on for voice 7 in the very cycle voice 7 is written back
        sweep(1'b1, 7, 7, 1'b1, 1'b0, 7'd90);
        sweep(1'b0, 0, 0, 1'b0, 1'b0, 7'd0);

        // one tick starts a sweep, two more arrive during it
        b0 = busy_cnt;
        o0 = ovr_cnt;
        model_sweep(1'b0, 0, 0, 1'b0, 1'b0, 7'd0);
        model_sweep(1'b0, 0, 0, 1'b0, 1'b0, 7'd0);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        for (int j = 0; j < 2 * NV; j++) begin
            tick = (j == 2 || j == 5);
            @(posedge clk); #1;
            tick = 1'b0;
        end
        check("busy_after_double", 64'(busy), 64'd0);
        check("busy_len_double", 64'(busy_cnt - b0), 64'd32);
        check("overrun_pulses", 64'(ovr_cnt - o0), 64'd1);

        // simultaneous note_on and note_off on voice 0
        note(0, 1'b1, 1'b1, 7'd33);
        sweep(1'b0, 0, 0, 1'b0, 1'b0, 7'd0);

        // randomized events, idle and mid-sweep
        for (int it = 0; it < 40; it++) begin
            int n_ev;
            int kind;
            n_ev = $urandom_range(0, 3);
            for (int e = 0; e < n_ev; e++) begin
                kind = $urandom_range(0, 2);
                note($urandom_range(0, NV - 1), kind != 1, kind != 0, 7'($urandom_range(0, 127)));
            end
            kind = $urandom_range(0, 2);
            sweep(1'($urandom_range(0, 1)), $urandom_range(0, NV - 1), $urandom_range(0, NV - 1),
                  kind != 1, kind != 0, 7'($urandom_range(0, 127)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        check("ctx_q_drained", 64'(exp_ctx_q.size()), 64'd0);
        check("env_q_drained", 64'(exp_env_q.size()), 64'd0);
        check("overrun_total", 64'(ovr_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
